fifo_controller: RTL and testbench

//  Control FSM and pointer generator that sequences the dual-port FIFO memory
//  (memoria) as a circular buffer.

---
 rtl/fifo_ctrl_pkg.sv | 15 +
 rtl/fifo_ptr.sv | 26 ++
 rtl/fifo_controller.sv | 121 ++++++++++++
 tb/tb_fifo_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default sizing for the FIFO controller, its memory and the bench.
package fifo_ctrl_pkg;

  localparam int DEFAULT_ADDR_WIDTH   = 3;
  localparam int DEFAULT_DEPTH        = 2 ** DEFAULT_ADDR_WIDTH;
  localparam int DEFAULT_AF_THRESHOLD = 2;
  localparam int DEFAULT_AE_THRESHOLD = 2;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/fifo_ptr.sv
// Enable-driven circular address counter; wraps DEPTH-1 -> 0 by natural modulo.
module fifo_ptr #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] ptr
);

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = ptr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_controller.sv
// Circular-buffer sequencer for the dual-port FIFO memory: pointers, occupancy,
// threshold flags and sticky error reporting. No data passes through here.
module fifo_controller
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int AF_THRESHOLD = DEFAULT_AF_THRESHOLD,
  parameter int AE_THRESHOLD = DEFAULT_AE_THRESHOLD
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  data_valid,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESHOLD);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESHOLD);

  fifo_state_t   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          dv_q, dv_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic wr_acc;
  logic rd_acc;

  // Gating with reset_L keeps the memory strobes quiet while reset is held.
  assign wr_acc = reset_L & push & (~full_q | pop);
  assign rd_acc = reset_L & pop & ~empty_q;

  always_comb begin
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = ((DEPTH_C - count_d) <= AF_C);
    ae_d    = (count_d <= AE_C);
    dv_d    = rd_acc;
    ovf_d   = ovf_q | (push & full_q & ~pop);
    unf_d   = unf_q | (pop & empty_q);

    state_d = state_q;
    case (state_q)
      ST_EMPTY:  if (wr_acc) state_d = full_d ? ST_FULL : ST_ACTIVE;
      ST_ACTIVE: begin
        if (full_d)       state_d = ST_FULL;
        else if (empty_d) state_d = ST_EMPTY;
      end
      ST_FULL:   if (rd_acc && !wr_acc) state_d = empty_d ? ST_EMPTY : ST_ACTIVE;
      default:   state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .en      (wr_acc),
    .ptr     (wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .en      (rd_acc),
    .ptr     (rd_ptr)
  );

  assign write_enable = wr_acc;
  assign read_enable  = rd_acc;
  assign fifo_count   = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign data_valid   = dv_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_controller.sv
// Directed bench for fifo_controller with a read-before-write 8x8 memory model.
module tb_fifo_controller;
  import fifo_ctrl_pkg::*;

  localparam int AW = DEFAULT_ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          push, pop;
  logic [7:0]    data_in;
  logic          write_enable, read_enable;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic          full, empty, almost_full, almost_empty;
  logic          data_valid, overflow, underflow;

  logic [7:0]    mem [DEFAULT_DEPTH];
  logic [7:0]    fifo_data_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fifo_controller dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .pop          (pop),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .fifo_count   (fifo_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_valid   (data_valid),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always @(posedge clk) begin
    if (read_enable)  fifo_data_out <= mem[rd_ptr];
    if (write_enable) mem[wr_ptr]   <= data_in;
  end

  always @(negedge clk) begin
    if (reset_L) begin
      assert (full == (dut.state_q == ST_FULL) && empty == (dut.state_q == ST_EMPTY))
        else $error("state/flag disagreement");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; push = 1'b1; pop = 1'b1; data_in = 8'h00;
    tick(); tick();
    n_total++; if (wr_ptr !== 3'd0) $display("FAIL reset_wr_ptr got %0d want 0", wr_ptr); else n_pass++;
    n_total++; if (rd_ptr !== 3'd0) $display("FAIL reset_rd_ptr got %0d want 0", rd_ptr); else n_pass++;
    n_total++; if (fifo_count !== 4'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else n_pass++;
    n_total++; if ({empty, almost_empty, full, almost_full} !== 4'b1100)
      $display("FAIL reset_flags got %b want 1100", {empty, almost_empty, full, almost_full}); else n_pass++;
    n_total++; if ({data_valid, overflow, underflow} !== 3'b000)
      $display("FAIL reset_status got %b want 000", {data_valid, overflow, underflow}); else n_pass++;
    n_total++; if ({write_enable, read_enable} !== 2'b00)
      $display("FAIL reset_enables got %b want 00", {write_enable, read_enable}); else n_pass++;
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    reset_L = 1'b1;
  endtask

  task automatic test_fill();
    logic [3:0] exp_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      push = 1'b1; data_in = 8'(8'h10 + i);
      #1;
      n_total++; if (write_enable !== 1'b1) $display("FAIL fill_we[%0d] got %b want 1", i, write_enable); else n_pass++;
      tick();
      exp_cnt = 4'(i + 1);
      n_total++; if (fifo_count !== exp_cnt) $display("FAIL fill_count[%0d] got %0d want %0d", i, fifo_count, exp_cnt); else n_pass++;
      n_total++; if (almost_full !== (i >= 5)) $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i >= 5)); else n_pass++;
      n_total++; if (full !== (i == 7)) $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 7)); else n_pass++;
      n_total++; if (wr_ptr !== 3'(i + 1)) $display("FAIL fill_wr_ptr[%0d] got %0d want %0d", i, wr_ptr, 3'(i + 1)); else n_pass++;
    end
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic test_overflow();
    @(negedge clk);
    push = 1'b1; data_in = 8'hEE;
    #1;
    n_total++; if (write_enable !== 1'b0) $display("FAIL ovf_we got %b want 0", write_enable); else n_pass++;
    tick();
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else n_pass++;
    n_total++; if (fifo_count !== 4'd8) $display("FAIL ovf_count got %0d want 8", fifo_count); else n_pass++;
    n_total++; if (wr_ptr !== 3'd0) $display("FAIL ovf_wr_ptr got %0d want 0", wr_ptr); else n_pass++;
    @(negedge clk);
    push = 1'b0;
    tick();
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
  endtask

  task automatic test_drain();
    logic [3:0] exp_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pop = 1'b1;
      #1;
      n_total++; if (read_enable !== 1'b1) $display("FAIL drain_re[%0d] got %b want 1", i, read_enable); else n_pass++;
      tick();
      exp_cnt = 4'(7 - i);
      n_total++; if (data_valid !== 1'b1) $display("FAIL drain_dv[%0d] got %b want 1", i, data_valid); else n_pass++;
      n_total++; if (fifo_data_out !== 8'(8'h10 + i))
        $display("FAIL drain_data[%0d] got %h want %h", i, fifo_data_out, 8'(8'h10 + i)); else n_pass++;
      n_total++; if (fifo_count !== exp_cnt) $display("FAIL drain_count[%0d] got %0d want %0d", i, fifo_count, exp_cnt); else n_pass++;
      n_total++; if (almost_empty !== (i >= 5)) $display("FAIL drain_ae[%0d] got %b want %b", i, almost_empty, (i >= 5)); else n_pass++;
      n_total++; if (empty !== (i == 7)) $display("FAIL drain_empty[%0d] got %b want %b", i, empty, (i == 7)); else n_pass++;
    end
    n_total++; if (rd_ptr !== 3'd0) $display("FAIL drain_rd_ptr got %0d want 0", rd_ptr); else n_pass++;
    n_total++; if (underflow !== 1'b0) $display("FAIL drain_unf got %b want 0", underflow); else n_pass++;
    @(negedge clk);
    pop = 1'b0;
    tick();
    n_total++; if (data_valid !== 1'b0) $display("FAIL drain_dv_idle got %b want 0", data_valid); else n_pass++;
  endtask

  task automatic test_simultaneous();
    // pop on empty
    @(negedge clk);
    pop = 1'b1;
    #1;
    n_total++; if (read_enable !== 1'b0) $display("FAIL unf_re got %b want 0", read_enable); else n_pass++;
    tick();
    n_total++; if (underflow !== 1'b1) $display("FAIL unf_flag got %b want 1", underflow); else n_pass++;
    n_total++; if (rd_ptr !== 3'd0 || fifo_count !== 4'd0)
      $display("FAIL unf_state got ptr %0d cnt %0d want 0 0", rd_ptr, fifo_count); else n_pass++;
    // push+pop on empty: only the write lands
    @(negedge clk);
    push = 1'b1; pop = 1'b1; data_in = 8'hA0;
    #1;
    n_total++; if ({write_enable, read_enable} !== 2'b10)
      $display("FAIL pp_empty_en got %b want 10", {write_enable, read_enable}); else n_pass++;
    tick();
    n_total++; if (fifo_count !== 4'd1 || empty !== 1'b0)
      $display("FAIL pp_empty_count got cnt %0d empty %b want 1 0", fifo_count, empty); else n_pass++;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      push = 1'b1; pop = 1'b0; data_in = 8'(8'hA0 + i);
      tick();
    end
    n_total++; if (full !== 1'b1 || fifo_count !== 4'd8)
      $display("FAIL refill got full %b cnt %0d want 1 8", full, fifo_count); else n_pass++;
    // push+pop while full: read-before-write, count holds
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push = 1'b1; pop = 1'b1; data_in = 8'(8'hB0 + i);
      #1;
      n_total++; if ({write_enable, read_enable} !== 2'b11)
        $display("FAIL pp_full_en[%0d] got %b want 11", i, {write_enable, read_enable}); else n_pass++;
      tick();
      n_total++; if (fifo_data_out !== 8'(8'hA0 + i) || data_valid !== 1'b1)
        $display("FAIL pp_full_data[%0d] got %h dv %b want %h 1", i, fifo_data_out, data_valid, 8'(8'hA0 + i)); else n_pass++;
      n_total++; if (fifo_count !== 4'd8 || full !== 1'b1)
        $display("FAIL pp_full_count[%0d] got %0d want 8", i, fifo_count); else n_pass++;
      n_total++; if (wr_ptr !== rd_ptr || wr_ptr !== 3'(i + 1))
        $display("FAIL pp_full_ptrs[%0d] got wr %0d rd %0d want %0d", i, wr_ptr, rd_ptr, 3'(i + 1)); else n_pass++;
    end
    n_total++; if (overflow !== 1'b1) $display("FAIL pp_full_ovf got %b want 1", overflow); else n_pass++;
    // one pop, then push+pop at count 7
    @(negedge clk);
    push = 1'b0; pop = 1'b1;
    tick();
    n_total++; if (fifo_data_out !== 8'hA3 || fifo_count !== 4'd7)
      $display("FAIL mid_pop got %h cnt %0d want a3 7", fifo_data_out, fifo_count); else n_pass++;
    @(negedge clk);
    push = 1'b1; pop = 1'b1; data_in = 8'hB3;
    tick();
    n_total++; if (fifo_data_out !== 8'hA4 || fifo_count !== 4'd7 || full !== 1'b0)
      $display("FAIL pp_mid got %h cnt %0d full %b want a4 7 0", fifo_data_out, fifo_count, full); else n_pass++;
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pop = 1'b1;
      tick();
    end
    n_total++; if (fifo_count !== 4'd5 || fifo_data_out !== 8'hA6)
      $display("FAIL pre_reset got cnt %0d data %h want 5 a6", fifo_count, fifo_data_out); else n_pass++;
    @(negedge clk);
    pop = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    n_total++; if (fifo_count !== 4'd0 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0)
      $display("FAIL async_ptrs got cnt %0d wr %0d rd %0d want 0 0 0", fifo_count, wr_ptr, rd_ptr); else n_pass++;
    n_total++; if ({empty, almost_empty, full, almost_full, data_valid, overflow, underflow} !== 7'b1100000)
      $display("FAIL async_flags got %b want 1100000",
               {empty, almost_empty, full, almost_full, data_valid, overflow, underflow}); else n_pass++;
    @(negedge clk);
    reset_L = 1'b1;
    push = 1'b1; data_in = 8'hC5;
    #1;
    n_total++; if (write_enable !== 1'b1 || wr_ptr !== 3'd0)
      $display("FAIL post_reset_push got we %b wr %0d want 1 0", write_enable, wr_ptr); else n_pass++;
    tick();
    n_total++; if (fifo_count !== 4'd1) $display("FAIL post_reset_count got %0d want 1", fifo_count); else n_pass++;
    @(negedge clk);
    push = 1'b0; pop = 1'b1;
    tick();
    n_total++; if (fifo_data_out !== 8'hC5 || data_valid !== 1'b1 || empty !== 1'b1)
      $display("FAIL post_reset_pop got %h dv %b empty %b want c5 1 1", fifo_data_out, data_valid, empty); else n_pass++;
    @(negedge clk);
    pop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule
